run_controller: RTL and testbench

//  Sequences the core through the bench Start/Ack protocol for multi-program runs.
//  On Start it holds the PC at the selected program's base address. When Start

---
 rtl/run_controller_pkg.sv | 22 ++
 rtl/run_controller_sat_counter.sv | 30 +++
 rtl/run_controller.sv | 124 ++++++++++++
 tb/tb_run_controller.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/run_controller_pkg.sv
`default_nettype none
// ============================================================================
// run_ctrl_pkg : shared state encoding and default parameters, run controller
// Rev 1.0
// ============================================================================
package run_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ARM  = 2'd1,
      RUN  = 2'd2,
      DONE = 2'd3
   } run_state_t;

   localparam int PC_W_DEF     = 10;
   localparam int CNT_W_DEF    = 16;
   localparam int NUM_PROG_DEF = 3;
   // Program i occupies bits [i*PC_W +: PC_W], so slice 0 sits at the LSB end.
   localparam logic [PC_W_DEF*NUM_PROG_DEF-1:0] BASE_ADDRS_DEF = {10'd512, 10'd256, 10'd0};

endpackage
`default_nettype wire

// File: rtl/run_controller_sat_counter.sv
`default_nettype none
// ============================================================================
// sat_counter : clearable up-counter that sticks at all-ones
// Rev 1.0
// ============================================================================
module sat_counter #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear,
   input  logic             inc,
   input  logic             en,
   output logic [CNT_W-1:0] count
);

   localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (en && inc && (count != '1)) begin
         count <= count + ONE;
      end
   end

endmodule
`default_nettype wire

// File: rtl/run_controller.sv
`default_nettype none
// ============================================================================
// run_controller : Start/Ack run sequencer with watchdog and run counters
// Rev 1.0
// ============================================================================
module run_controller
   import run_ctrl_pkg::*;
#(
   parameter int                       PC_W       = PC_W_DEF,
   parameter int                       CNT_W      = CNT_W_DEF,
   parameter int                       NUM_PROG   = NUM_PROG_DEF,
   parameter logic [PC_W*NUM_PROG-1:0] BASE_ADDRS = BASE_ADDRS_DEF,
   parameter logic [CNT_W-1:0]         WDOG_LIMIT = CNT_W'(60000)
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             Start,
   input  logic [1:0]       ProgSel,
   input  logic             Halt,
   input  logic             InstRetire,
   output logic             PcInit,
   output logic [PC_W-1:0]  ProgBase,
   output logic             CoreEn,
   output logic             Ack,
   output logic             Timeout,
   output logic [CNT_W-1:0] CycleCnt,
   output logic [CNT_W-1:0] InstCnt
);

   localparam logic [CNT_W-1:0] WDOG_LAST = WDOG_LIMIT - {{(CNT_W-1){1'b0}}, 1'b1};

   run_state_t      state;
   run_state_t      next_state;
   logic [PC_W-1:0] sel_base;
   logic            wdog_hit;
   logic            in_run;
   logic            cnt_clear;

   generate
      if (WDOG_LIMIT != '0) begin : g_wdog
         assign wdog_hit = (CycleCnt == WDOG_LAST);
      end else begin : g_no_wdog
         assign wdog_hit = 1'b0;
      end
   endgenerate

   // Out-of-range selections fall back to program 0.
   always_comb begin
      sel_base = BASE_ADDRS[PC_W-1:0];
      for (int i = 0; i < NUM_PROG; i++) begin
         if (int'(ProgSel) == i) begin
            sel_base = BASE_ADDRS[i*PC_W +: PC_W];
         end
      end
   end

   assign in_run    = (state == RUN);
   // An abort clears on the same edge that re-enters ARM, so Ack never sees stale counts.
   assign cnt_clear = (state == ARM) || (in_run && Start);

   always_comb begin
      next_state = state;
      PcInit     = 1'b0;
      CoreEn     = 1'b0;
      Ack        = 1'b0;
      case (state)
         IDLE: begin
            PcInit = 1'b1;
            if (Start) next_state = ARM;
         end
         ARM: begin
            PcInit = 1'b1;
            if (!Start) next_state = RUN;
         end
         RUN: begin
            CoreEn = 1'b1;
            if (Start)                  next_state = ARM;
            else if (Halt || wdog_hit)  next_state = DONE;
         end
         DONE: begin
            Ack = 1'b1;
            if (Start) next_state = ARM;
         end
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state    <= IDLE;
         ProgBase <= BASE_ADDRS[PC_W-1:0];
         Timeout  <= 1'b0;
      end else begin
         state <= next_state;
         if (state == ARM) begin
            ProgBase <= sel_base;
            Timeout  <= 1'b0;
         end else if (in_run && (next_state == DONE)) begin
            // Halt takes precedence when it coincides with watchdog expiry.
            Timeout <= !Halt;
         end
      end
   end

   sat_counter #(.CNT_W(CNT_W)) u_cycle_cnt (
      .clk   (Clk),
      .rst_n (Reset),
      .clear (cnt_clear),
      .inc   (1'b1),
      .en    (in_run),
      .count (CycleCnt)
   );

   sat_counter #(.CNT_W(CNT_W)) u_inst_cnt (
      .clk   (Clk),
      .rst_n (Reset),
      .clear (cnt_clear),
      .inc   (InstRetire),
      .en    (in_run),
      .count (InstCnt)
   );

endmodule
`default_nettype wire

// File: tb/tb_run_controller.sv
`default_nettype none
// ============================================================================
// tb_run_controller : scoreboard bench for run_controller (watchdog = 50)
// Rev 1.0
// ============================================================================
module tb_run_controller;

   localparam int WDOG = 50;

   logic        Clk = 1'b0;
   logic        Reset;
   logic        Start;
   logic [1:0]  ProgSel;
   logic        Halt;
   logic        InstRetire;
   logic        PcInit;
   logic [9:0]  ProgBase;
   logic        CoreEn;
   logic        Ack;
   logic        Timeout;
   logic [15:0] CycleCnt;
   logic [15:0] InstCnt;

   typedef struct {
      logic [9:0]  base;
      logic [15:0] cyc;
      logic [15:0] inst;
      logic        to;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   always #5 Clk = ~Clk;

   run_controller #(
      .WDOG_LIMIT(16'd50)
   ) dut (
      .Clk        (Clk),
      .Reset      (Reset),
      .Start      (Start),
      .ProgSel    (ProgSel),
      .Halt       (Halt),
      .InstRetire (InstRetire),
      .PcInit     (PcInit),
      .ProgBase   (ProgBase),
      .CoreEn     (CoreEn),
      .Ack        (Ack),
      .Timeout    (Timeout),
      .CycleCnt   (CycleCnt),
      .InstCnt    (InstCnt)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_checks++;
      if (obs !== expv) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, expv);
      end
   endtask

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   // sel: ProgSel, hold: Start-high cycles, halt_cyc: RUN cycle carrying Halt (0 = none),
   // n_ret: retire pulses in RUN cycles 1..n_ret, abort_at: RUN cycle raising Start (0 = none)
   task automatic do_run(input int sel, input int hold, input int halt_cyc,
                         input int n_ret, input int abort_at);
      exp_t e;
      exp_t got;
      int   k;
      bit   aborted;
      bit   halted;
      Start   = 1'b1;
      ProgSel = sel[1:0];
      tick();
      check("ack_drop", Ack, 0);
      check("arm_pcinit", PcInit, 1);
      for (int i = 1; i < hold; i++) tick();
      Start = 1'b0;
      tick();
      check("launch_coreen", CoreEn, 1);
      check("launch_pcinit", PcInit, 0);
      check("launch_cyc", CycleCnt, 0);

      halted = (halt_cyc != 0) && (halt_cyc <= WDOG);
      e.base = (sel == 1) ? 10'd256 : (sel == 2) ? 10'd512 : 10'd0;
      e.cyc  = halted ? 16'(halt_cyc) : 16'(WDOG);
      e.inst = (n_ret < int'(e.cyc)) ? 16'(n_ret) : e.cyc;
      e.to   = !halted;
      if (abort_at == 0) sb.push_back(e);

      k       = 0;
      aborted = 1'b0;
      while (!Ack && !aborted && k < 200) begin
         k++;
         InstRetire = (k <= n_ret);
         Halt       = (k == halt_cyc);
         if (k == abort_at) begin
            Start = 1'b1;
            tick();
            aborted = 1'b1;
            check("abort_coreen", CoreEn, 0);
            check("abort_pcinit", PcInit, 1);
            check("abort_cyc", CycleCnt, 0);
            check("abort_inst", InstCnt, 0);
            check("abort_ack", Ack, 0);
         end else begin
            tick();
         end
      end
      Halt       = 1'b0;
      InstRetire = 1'b0;
      if (aborted) return;

      check("ack_seen", Ack, 1);
      check("ack_cycle", k, e.cyc);
      if (sb.size() == 0) begin
         check("sb_empty", 0, 1);
      end else begin
         got = sb.pop_front();
         check("prog_base", ProgBase, got.base);
         check("cycle_cnt", CycleCnt, got.cyc);
         check("inst_cnt", InstCnt, got.inst);
         check("timeout", Timeout, got.to);
      end
      Halt       = 1'b1;
      InstRetire = 1'b1;
      tick();
      tick();
      Halt       = 1'b0;
      InstRetire = 1'b0;
      check("done_frozen_cyc", CycleCnt, e.cyc);
      check("done_frozen_inst", InstCnt, e.inst);
      check("done_ack_hold", Ack, 1);
   endtask

   initial begin
      #100000;
      $display("FAIL global_time_limit: got 0, expected 1");
      $fatal(1, "time limit");
   end

   initial begin
      Reset      = 1'b0;
      Start      = 1'b0;
      ProgSel    = 2'd0;
      Halt       = 1'b0;
      InstRetire = 1'b0;
      repeat (3) tick();
      check("rst_pcinit", PcInit, 1);
      check("rst_coreen", CoreEn, 0);
      check("rst_ack", Ack, 0);
      check("rst_timeout", Timeout, 0);
      Reset = 1'b1;
      tick();
      check("idle_pcinit", PcInit, 1);
      check("idle_coreen", CoreEn, 0);
      check("idle_ack", Ack, 0);
      check("idle_cyc", CycleCnt, 0);
      check("idle_base", ProgBase, 0);

      do_run(1, 2, 21, 15, 0);         // halt run on program 1
      do_run(0, 2, 0, 3, 0);           // watchdog expiry
      do_run(1, 2, 0, 4, 10);          // abort at RUN cycle 10
      do_run(2, 2, 7, 7, 0);           // relaunch on program 2
      do_run(0, 1, 5, 2, 0);           // back-to-back single-cycle Start pulses
      do_run(1, 1, 8, 8, 0);
      do_run(2, 1, 3, 0, 0);
      do_run(3, 1, 4, 1, 0);           // out-of-range select falls back to slice 0
      do_run(1, 2, WDOG, 5, 0);        // Halt coincides with watchdog expiry

      Start   = 1'b1;
      ProgSel = 2'd2;
      tick();
      Start      = 1'b0;
      tick();
      InstRetire = 1'b1;
      repeat (5) tick();
      check("pre_reset_coreen", CoreEn, 1);
      #3 Reset = 1'b0;
      #1;
      check("midrun_rst_pcinit", PcInit, 1);
      check("midrun_rst_coreen", CoreEn, 0);
      check("midrun_rst_ack", Ack, 0);
      check("midrun_rst_cyc", CycleCnt, 0);
      check("midrun_rst_inst", InstCnt, 0);
      check("midrun_rst_base", ProgBase, 0);
      check("midrun_rst_timeout", Timeout, 0);
      InstRetire = 1'b0;
      tick();
      Reset = 1'b1;
      tick();
      check("post_rst_idle", PcInit, 1);
      check("post_rst_cyc", CycleCnt, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
